// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared button indices and repeat FSM encoding
package game_pkg;

    localparam int NUM_BTNS   = 5;
    localparam int NUM_DIRS   = 4;
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_SELECT = 4;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser, stability debouncer and press edge pulse
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic state_o,
    output logic held_o,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          state_q;
    logic          state_d;
    logic          held_q;
    logic          press_q;

    // Any cycle of agreement restarts the stability count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= 1'b0;
            held_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            held_q  <= state_q;
            press_q <= state_q & ~held_q;
        end
    end

    assign state_o = state_q;
    assign held_o  = held_q;
    assign press_o = press_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced press pulses with direction auto-repeat and priority arbitration
module button_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 40_000_000,
    parameter int REPEAT_RATE     = 15_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                up_raw,
    input  logic                down_raw,
    input  logic                left_raw,
    input  logic                right_raw,
    input  logic                select_raw,
    output logic                up_pulse,
    output logic                down_pulse,
    output logic                left_pulse,
    output logic                right_pulse,
    output logic                select_pulse,
    output logic [NUM_BTNS-1:0] btn_held
);

    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [NUM_BTNS-1:0] raw_vec;
    logic [NUM_BTNS-1:0] deb_state;
    logic [NUM_BTNS-1:0] deb_press;
    logic [NUM_BTNS-1:0] press_ok;

    rpt_state_e          rpt_q  [NUM_DIRS];
    rpt_state_e          rpt_d  [NUM_DIRS];
    logic [RW-1:0]       rcnt_q [NUM_DIRS];
    logic [RW-1:0]       rcnt_d [NUM_DIRS];
    logic [NUM_DIRS-1:0] rep_fire;
    logic [NUM_DIRS-1:0] dir_req;
    logic [NUM_DIRS-1:0] dir_grant;
    logic [NUM_BTNS-1:0] pulse_d;
    logic [NUM_BTNS-1:0] pulse_q;

    assign raw_vec[BTN_UP]     = up_raw;
    assign raw_vec[BTN_DOWN]   = down_raw;
    assign raw_vec[BTN_LEFT]   = left_raw;
    assign raw_vec[BTN_RIGHT]  = right_raw;
    assign raw_vec[BTN_SELECT] = select_raw;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (raw_vec[g]),
            .state_o(deb_state[g]),
            .held_o (btn_held[g]),
            .press_o(deb_press[g])
        );
    end

    assign press_ok = deb_press & deb_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIRS; i++) begin
                rpt_q[i]  <= RPT_IDLE;
                rcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIRS; i++) begin
                rpt_q[i]  <= rpt_d[i];
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIRS; i++) begin
            rpt_d[i]  = rpt_q[i];
            rcnt_d[i] = rcnt_q[i];
            if (!deb_state[i]) begin
                rpt_d[i]  = RPT_IDLE;
                rcnt_d[i] = '0;
            end else begin
                case (rpt_q[i])
                    RPT_IDLE: begin
                        if (press_ok[i]) begin
                            rpt_d[i]  = RPT_DELAY;
                            rcnt_d[i] = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (rcnt_q[i] == DELAY_LAST) begin
                            rpt_d[i]  = RPT_REPEAT;
                            rcnt_d[i] = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (rcnt_q[i] == RATE_LAST) begin
                            rcnt_d[i] = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RW'(1);
                        end
                    end
                    default: begin
                        rpt_d[i]  = RPT_IDLE;
                        rcnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // Repeats are gated by the live debounced state, so a release landing on the
    // firing edge suppresses that repeat. Lower index wins; losers are dropped.
    always_comb begin
        rep_fire  = '0;
        dir_grant = '0;
        for (int i = 0; i < NUM_DIRS; i++) begin
            rep_fire[i] = deb_state[i] &&
                          (((rpt_q[i] == RPT_DELAY)  && (rcnt_q[i] == DELAY_LAST)) ||
                           ((rpt_q[i] == RPT_REPEAT) && (rcnt_q[i] == RATE_LAST)));
        end
        dir_req = press_ok[NUM_DIRS-1:0] | rep_fire;
        for (int i = NUM_DIRS - 1; i >= 0; i--) begin
            if (dir_req[i]) begin
                dir_grant    = '0;
                dir_grant[i] = 1'b1;
            end
        end
        pulse_d                 = '0;
        pulse_d[NUM_DIRS-1:0]   = dir_grant;
        pulse_d[BTN_SELECT]     = press_ok[BTN_SELECT];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign up_pulse     = pulse_q[BTN_UP];
    assign down_pulse   = pulse_q[BTN_DOWN];
    assign left_pulse   = pulse_q[BTN_LEFT];
    assign right_pulse  = pulse_q[BTN_RIGHT];
    assign select_pulse = pulse_q[BTN_SELECT];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic up_raw, down_raw, left_raw, right_raw, select_raw;
    logic up_pulse, down_pulse, left_pulse, right_pulse, select_pulse;
    logic [4:0] btn_held;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pcnt [5] = '{default: 0};
    int base [5];
    int c, p, e0;
    int rep_off [6] = '{0, 20, 28, 36, 44, 52};

    wire [4:0] pulses = {select_pulse, right_pulse, left_pulse, down_pulse, up_pulse};

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .up_raw      (up_raw),
        .down_raw    (down_raw),
        .left_raw    (left_raw),
        .right_raw   (right_raw),
        .select_raw  (select_raw),
        .up_pulse    (up_pulse),
        .down_pulse  (down_pulse),
        .left_pulse  (left_pulse),
        .right_pulse (right_pulse),
        .select_pulse(select_pulse),
        .btn_held    (btn_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (pulses[i] === 1'b1) pcnt[i] = pcnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_raw(input logic [4:0] v);
        {select_raw, right_raw, left_raw, down_raw, up_raw} = v;
    endtask

    task automatic snap();
        for (int i = 0; i < 5; i++) base[i] = pcnt[i];
    endtask

    initial begin
        reset = 1'b0;
        set_raw(5'h1F);

        // reset held with every button pressed
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_out", 32'({pulses, btn_held}), 32'h0);
        end
        reset = 1'b1;
        e0 = cyc + 1;
        snap();
        goto(e0 + 6);
        chk("rst_held", 32'(btn_held), 32'h1F);
        chk("rst_pre_pulse", 32'(pulses), 32'h0);
        goto(e0 + 7);
        chk("rst_press", 32'(pulses), 32'h11);
        goto(e0 + 8);
        chk("rst_width", 32'(pulses), 32'h0);
        set_raw(5'h0);
        goto(e0 + 40);
        chk("rst_up_cnt", pcnt[0] - base[0], 1);
        chk("rst_down_cnt", pcnt[1] - base[1], 0);
        chk("rst_left_cnt", pcnt[2] - base[2], 0);
        chk("rst_right_cnt", pcnt[3] - base[3], 0);
        chk("rst_sel_cnt", pcnt[4] - base[4], 1);
        chk("rst_release_held", 32'(btn_held), 32'h0);

        // select: single pulse, never repeats
        c = cyc;
        snap();
        set_raw(5'b10000);
        goto(c + 6);
        chk("sel_held_pre", 32'(btn_held[4]), 32'h0);
        goto(c + 7);
        chk("sel_held", 32'(btn_held[4]), 32'h1);
        chk("sel_no_early", 32'(pulses), 32'h0);
        goto(c + 8);
        chk("sel_press", 32'(pulses), 32'h10);
        goto(c + 30);
        set_raw(5'h0);
        goto(c + 60);
        chk("sel_cnt", pcnt[4] - base[4], 1);
        chk("sel_release_held", 32'(btn_held), 32'h0);

        // left bounces 1,0,1,0 then holds
        c = cyc;
        snap();
        for (int k = 0; k < 4; k++) begin
            set_raw((k % 2 == 0) ? 5'b00100 : 5'b00000);
            @(posedge clk);
            #1;
        end
        set_raw(5'b00100);
        goto(c + 10);
        chk("bounce_held_pre", 32'(btn_held[2]), 32'h0);
        chk("bounce_cnt_pre", pcnt[2] - base[2], 0);
        goto(c + 11);
        chk("bounce_held", 32'(btn_held[2]), 32'h1);
        goto(c + 12);
        chk("bounce_press", 32'(pulses), 32'h04);
        goto(c + 13);
        set_raw(5'h0);
        goto(c + 50);
        chk("bounce_cnt", pcnt[2] - base[2], 1);

        // right held: press then repeats at +20, +28, ...
        c = cyc;
        snap();
        set_raw(5'b01000);
        p = c + 8;
        for (int k = 0; k < 6; k++) begin
            goto(p + rep_off[k]);
            chk($sformatf("right_rep%0d", k), 32'(pulses), 32'h08);
        end
        goto(p + 53);
        set_raw(5'h0);
        goto(p + 59);
        chk("right_held_pre", 32'(btn_held[3]), 32'h1);
        goto(p + 60);
        chk("right_held_fall", 32'(btn_held[3]), 32'h0);
        chk("right_suppressed", 32'(pulses), 32'h0);
        goto(p + 90);
        chk("right_cnt", pcnt[3] - base[3], 6);

        // up and down together: up always wins
        c = cyc;
        snap();
        set_raw(5'b00011);
        p = c + 8;
        goto(p);
        chk("updown_press", 32'(pulses), 32'h01);
        goto(p + 20);
        chk("updown_rep1", 32'(pulses), 32'h01);
        goto(p + 28);
        chk("updown_rep2", 32'(pulses), 32'h01);
        goto(p + 29);
        set_raw(5'h0);
        goto(p + 60);
        chk("updown_down_cnt", pcnt[1] - base[1], 0);
        chk("updown_up_cnt", pcnt[0] - base[0], 3);

        // one-cycle reset mid-DELAY on held down
        c = cyc;
        snap();
        set_raw(5'b00010);
        p = c + 8;
        goto(p);
        chk("rd_press", 32'(pulses), 32'h02);
        goto(p + 10);
        reset = 1'b0;
        goto(p + 11);
        chk("rd_in_reset", 32'({pulses, btn_held}), 32'h0);
        reset = 1'b1;
        goto(p + 18);
        chk("rd_held_again", 32'(btn_held[1]), 32'h1);
        chk("rd_no_early", 32'(pulses), 32'h0);
        goto(p + 19);
        chk("rd_repress", 32'(pulses), 32'h02);
        goto(p + 38);
        chk("rd_cancelled", pcnt[1] - base[1], 2);
        goto(p + 39);
        chk("rd_new_repeat", 32'(pulses), 32'h02);
        set_raw(5'h0);
        goto(p + 70);
        chk("rd_cnt", pcnt[1] - base[1], 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
